// File: rtl/gate_seq_pkg.sv
// Shared definitions for the two-input gate exhaustive sequencer.
// State encoding and reference truth tables indexed by {gate_in1,gate_in2}.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_seq_settle_timer.sv
// Load/count-down settle timer: after a load, expire_o is high in the
// SETTLE_CYCLES-th enabled cycle.
module gate_seq_settle_timer
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/gate_exhaustive_sequencer.sv
// Sweeps a two-input gate through 00,01,10,11, checks each against a latched
// truth table. Optional first-failure log under `GATE_SEQ_FAIL_LOG_EN.
module gate_exhaustive_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       expected_tt,
  output logic             gate_in1,
  output logic             gate_in2,
  input  logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef GATE_SEQ_FAIL_LOG_EN
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
`endif
  output logic [ERR_W-1:0] err_count
);

  state_e           state_q, state_d;
  logic [3:0]       tt_q, tt_d;
  logic [1:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       ffvec_q, ffvec_d;
  logic             timer_load, timer_en, timer_expire;
  logic             mismatch;

  assign mismatch = (state_q == SAMPLE) && (gate_out != tt_q[vec_q]);

  always_comb begin
    state_d    = state_q;
    tt_d       = tt_q;
    vec_d      = vec_q;
    err_d      = err_q;
    pass_d     = pass_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tt_d       = expected_tt;
          vec_d      = '0;
          err_d      = '0;
          pass_d     = 1'b0;
          ffv_d      = 1'b0;
          ffvec_d    = '0;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
        if (mismatch && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec_q;
        end
        if (vec_q == 2'd3) begin
          // pass is registered on entry to DONE so it is already valid with done
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tt_q    <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  gate_seq_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .expire_o(timer_expire)
  );

  assign gate_in1  = vec_q[1];
  assign gate_in2  = vec_q[0];
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef GATE_SEQ_FAIL_LOG_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
`else
  logic unused_ff;
  assign unused_ff = ffv_q ^ ffvec_q[0] ^ ffvec_q[1];
`endif

endmodule

// File: tb/tb_gate_exhaustive_sequencer.sv
// Scoreboard bench: stimulus queues expected run results, a negedge monitor
// checks per-cycle timing and pops results on each done pulse.
module tb_gate_exhaustive_sequencer;
  import gate_seq_pkg::*;

  localparam int S       = 3;
  localparam int EW      = 3;
  localparam int S2      = 1;
  localparam int EW2     = 2;
  localparam int RUNLEN  = 4 * (S + 1) + 1;
  localparam int INVALID = -1000000;

  typedef struct {
    int err;
    bit pass;
    bit ffvalid;
    int ffvec;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, gate_in1, gate_in2, gate_out, busy, done, pass;
  logic [3:0]    expected_tt, model_tt;
  logic [EW-1:0] err_count;
  logic          start2, g2_in1, g2_in2, g2_out, busy2, done2, pass2;
  logic [EW2-1:0] err2;
`ifdef GATE_SEQ_FAIL_LOG_EN
  logic       ffv, ffv2;
  logic [1:0] ffvec, ffvec2;
`endif

  assign gate_out = model_tt[{gate_in1, gate_in2}];
  assign g2_out   = g2_in1 & g2_in2;

  gate_exhaustive_sequencer #(.SETTLE_CYCLES(S), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .expected_tt(expected_tt),
    .gate_in1(gate_in1), .gate_in2(gate_in2), .gate_out(gate_out),
    .busy(busy), .done(done), .pass(pass),
`ifdef GATE_SEQ_FAIL_LOG_EN
    .first_fail_valid(ffv), .first_fail_vec(ffvec),
`endif
    .err_count(err_count)
  );

  gate_exhaustive_sequencer #(.SETTLE_CYCLES(S2), .ERR_W(EW2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .expected_tt(TT_NAND),
    .gate_in1(g2_in1), .gate_in2(g2_in2), .gate_out(g2_out),
    .busy(busy2), .done(done2), .pass(pass2),
`ifdef GATE_SEQ_FAIL_LOG_EN
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2),
`endif
    .err_count(err2)
  );

  // Stimulus-owned state
  exp_t exp_arr[64];
  int   wr_cnt    = 0;
  int   c0        = INVALID;
  int   exp2_err  = -1;
  bit   final_chk = 1'b0;
  // Monitor-owned state
  int   rd_cnt    = 0;
  int   done2_cnt = 0;
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_run(input logic [3:0] act, input logic [3:0] want, input int ew);
    exp_t r;
    int   cnt;
    int   lim;
    cnt       = 0;
    lim       = (1 << ew) - 1;
    r.ffvalid = 1'b0;
    r.ffvec   = 0;
    for (int i = 0; i < 4; i++) begin
      if (act[i] != want[i]) begin
        if (!r.ffvalid) begin
          r.ffvalid = 1'b1;
          r.ffvec   = i;
        end
        cnt++;
      end
    end
    r.err  = (cnt > lim) ? lim : cnt;
    r.pass = (cnt == 0);
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    int  n;
    bit  act;
    n   = cyc - c0;
    act = (n >= 1) && (n <= RUNLEN);
    if (reset) begin
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_vec", int'({gate_in1, gate_in2}), 0);
      check("rst_busy2", int'(busy2), 0);
`ifdef GATE_SEQ_FAIL_LOG_EN
      check("rst_ffv", int'(ffv), 0);
      check("rst_ffvec", int'(ffvec), 0);
      check("rst_ffv2", int'(ffv2) + int'(ffvec2), 0);
`endif
    end else begin
      check("busy", int'(busy), int'(act && n <= 4 * (S + 1)));
      check("done", int'(done), int'(act && n == RUNLEN));
      if (act && n <= 4 * (S + 1))
        check("vec", int'({gate_in1, gate_in2}), (n - 1) / (S + 1));
      if (done) begin
        if (rd_cnt >= wr_cnt) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("err_count", int'(err_count), exp_arr[rd_cnt].err);
          check("pass", int'(pass), int'(exp_arr[rd_cnt].pass));
`ifdef GATE_SEQ_FAIL_LOG_EN
          check("ff_valid", int'(ffv), int'(exp_arr[rd_cnt].ffvalid));
          if (exp_arr[rd_cnt].ffvalid) check("ff_vec", int'(ffvec), exp_arr[rd_cnt].ffvec);
`endif
          rd_cnt++;
        end
      end
      if (done2) begin
        check("w2_err_sat", int'(err2), exp2_err);
        check("w2_pass", int'(pass2), 0);
        done2_cnt++;
      end
      if (final_chk) begin
        check("runs_completed", rd_cnt, wr_cnt);
        check("w2_runs", done2_cnt, 1);
      end
    end
  end

  task automatic start_run(input logic [3:0] m, input logic [3:0] e, input bit push);
    @(negedge clk);
    #1;
    model_tt    = m;
    expected_tt = e;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc - 1;
    if (push) begin
      exp_arr[wr_cnt] = ref_run(m, e, EW);
      wr_cnt++;
    end
  endtask

  // Advance to the given cycle of the current run (at least one negedge), then #1.
  task automatic goto_cycle(input int n);
    @(negedge clk);
    while (cyc - c0 < n) @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    start2      = 1'b0;
    model_tt    = 4'b0000;
    expected_tt = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;

    start_run(TT_AND, TT_AND, 1'b1);
    goto_cycle(RUNLEN);
    start_run(4'b0000, TT_AND, 1'b1);
    goto_cycle(RUNLEN);
    start_run(TT_OR, TT_AND, 1'b1);
    goto_cycle(RUNLEN + 2);

    // Narrow counter: four mismatches saturate at 3
    @(negedge clk);
    #1;
    start2 = 1'b1;
    exp2_err = ref_run(TT_AND, TT_NAND, EW2).err;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (4 * (S2 + 1) + 3) @(negedge clk);

    // Restarts while busy / in DONE and late expected_tt changes are ignored
    start_run(TT_AND, TT_AND, 1'b1);
    goto_cycle(3);
    start = 1'b1;
    goto_cycle(4);
    start = 1'b0;
    goto_cycle(5);
    expected_tt = TT_OR;
    goto_cycle(RUNLEN);
    start = 1'b1;
    goto_cycle(RUNLEN + 1);
    start = 1'b0;
    goto_cycle(RUNLEN + 3);

    // Abort by reset in cycle 6, then a clean run
    start_run(TT_AND, TT_AND, 1'b0);
    goto_cycle(6);
    reset = 1'b1;
    c0    = INVALID;
    goto_cycle(0);
    reset = 1'b0;
    start_run(TT_XOR, TT_XOR, 1'b1);
    goto_cycle(RUNLEN);

    for (int r = 0; r < 8; r++) begin
      start_run(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      goto_cycle(RUNLEN + int'($urandom_range(0, 3)));
    end

    final_chk = 1'b1;
    @(negedge clk);
    #1;
    final_chk = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_exhaustive_sequencer.md
# gate_exhaustive_sequencer

Self-checking controller that sequences a two-input logic gate under test through all four input combinations. For each vector it waits a programmable settle time, samples the gate output and compares it against a 4-bit expected truth table, then reports pass/fail and a mismatch count. It sits between a run-control source (bench or top-level control) and a two-input gate instance, replacing hand-written delay-driven stimulus with a clocked, repeatable sweep.

## Interface
- SETTLE_CYCLES, 3, cycles each vector is held before sampling; legal range ≥1
- ERR_W, 3, width of err_count; legal range ≥2

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  run request; accepted only in IDLE
- expected_tt  input  4  expected gate output, indexed by {gate_in1,gate_in2}; AND = 4'b1000
- gate_in1  output  1  registered drive to gate input 1
- gate_in2  output  1  registered drive to gate input 2
- gate_out  input  1  gate output being checked
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  1 when the last run had zero mismatches; held until the next accepted start
- err_count  output  ERR_W  mismatch count of the current or last run; saturating

Clock and reset are decided: one clock, `clk`; reset is synchronous and active-high, `reset`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - latch expected_tt into tt_q
  - set vec=0, err_count=0, pass=0
  - go to SETTLE
- SETTLE:
  - {gate_in1,gate_in2}=vec
  - settle counter runs SETTLE_CYCLES cycles, then goes to SAMPLE
- SAMPLE, one cycle:
  - if gate_out != tt_q[vec], increment err_count, saturating at 2^ERR_W-1
  - if vec==3, go to DONE; else vec+1, go to SETTLE
- DONE, one cycle:
  - done=1
  - pass=(final err_count==0)
  - go to IDLE
- Gate inputs hold the last vector (11) after the run until reset or the next start.
- The following are ignored:
  - start while busy or in DONE
  - expected_tt changes after acceptance
- Reset values: state IDLE, gate_in1=0, gate_in2=0, busy=0, done=0, pass=0, err_count=0, vec=0, settle counter=0.
- Reset mid-run aborts the run: no done pulse, all outputs take their reset values on the next edge.
- Reset has priority over start in the same cycle.
- Settle counter width: $clog2(SETTLE_CYCLES+1).

## Timing
- start is sampled at edge E0. Cycle n is the cycle after edge En.
- Vector k:
  - driven from cycle k·(S+1)+1
  - SETTLE occupies cycles k·(S+1)+1 … k·(S+1)+S
  - SAMPLE occupies cycle k·(S+1)+S+1
- err_count updates on the edge that ends SAMPLE.
- done is high in cycle 4·(S+1)+1 (cycle 17 for S=3). pass is valid from that cycle.
- busy is high in cycles 1 … 4·(S+1) and low in the DONE cycle.
- A new start is accepted earliest in the cycle after DONE.

## Configuration
- GATE_SEQ_FAIL_LOG_EN defined:
  - adds outputs first_fail_valid (1) and first_fail_vec (2)
  - on the first mismatch of a run, both register {1, vec}
  - both clear on accepted start and on reset
- Undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package gate_seq_pkg holds:
  - state encoding: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3
  - truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111
- One sub-module, gate_seq_settle_timer: load/count-down settle counter that pulses expire after SETTLE_CYCLES cycles.
- FSM, vector register, checker and error counter live in the top module.

## Test plan
1. AND gate model, expected_tt=TT_AND, S=3, start pulse -> inputs 00,01,10,11 each held 3 cycles + 1 sample cycle; done at cycle 17; pass=1; err_count=0.
2. Gate output stuck at 0, expected_tt=TT_AND -> err_count=1, pass=0; with macro, first_fail_valid=1 and first_fail_vec=2'b11.
3. OR gate model, expected_tt=TT_AND -> err_count=2 (vectors 01 and 10); first_fail_vec=2'b01.
4. Reset asserted in cycle 6 -> next cycle busy=0, inputs 00, err_count=0; no done pulse; a following start completes normally with done at +17.
5. start re-pulsed in cycles 3 and 17, expected_tt flipped to TT_OR in cycle 5 -> exactly one run, done only at cycle 17, result checked against TT_AND.
6. ERR_W=2, AND model, expected_tt=TT_NAND -> 4 mismatches; err_count saturates at 3; pass=0.
